ballot_session_ctrl: RTL and testbench
======================================

// Module: ballot_session_ctrl
// PURPOSE
//  Sequences one ballot per voter between the debounced candidate-button pulses
//  and the vote logger. The polling officer arms a ballot. The first button
//  event is accepted, and simultaneous presses spoil the ballot. After the event
//  a confirm window blocks further input until the next arm. The block emits a
//  one-hot cast strobe toward the logger and keeps session totals.
// PARAMETERS
//  NUM_CAND        4     number of candidates (width of vote_pulse/cast_onehot)
//  HOLD_CYCLES     10    confirm-window length in clock cycles, >=1
//  CNT_W           8     width of ballots_cast / spoiled_count
//  TIMEOUT_CYCLES  1000  armed-ballot expiry; used only with BALLOT_TIMEOUT_EN
// PORTS
//  clock          in   1         single clock, rising edge
//  reset          in   1         synchronous, active-low (0 = reset)
//  mode           in   1         0 = voting, 1 = result display
//  arm            in   1         officer pulse: arm ballot for next voter
//  vote_pulse     in   NUM_CAND  debounced 1-cycle press pulses, bit i = cand i+1
//  cast_onehot    out  NUM_CAND  1-cycle one-hot strobe to vote logger
//  armed          out  1         high while ballot is armed and awaiting a press
//  confirm        out  1         high during confirm window (drives LED flash)
//  spoiled        out  1         1-cycle pulse: ballot spoiled by multi-press
//  timeout        out  1         1-cycle pulse: armed ballot expired
//  ballots_cast   out  CNT_W     accepted ballots since reset, saturating
//  spoiled_count  out  CNT_W     spoiled ballots since reset, saturating
// BEHAVIOUR
//  - All outputs are registered. Reset (reset==0 at a clock edge) sets state
//    IDLE and drives every output and counter to 0. Reset wins over all
//    inputs. Reset mid-ARMED/HOLD aborts silently; no strobe is reissued.
//  - FSM states: IDLE, ARMED, HOLD.
//  - IDLE: arm==1 & mode==0 -> ARMED; armed=1 from the next cycle.
//    vote_pulse is ignored, and arm is ignored while mode==1.
//  - ARMED, evaluated in priority order:
//    1. mode==1 -> IDLE. Ballot withdrawn; no cast, no count.
//    2. exactly one vote_pulse bit set -> cast_onehot=vote_pulse next cycle,
//       for one cycle only; ballots_cast+1 -> HOLD.
//    3. >=2 vote_pulse bits set -> spoiled=1 next cycle, for one cycle;
//       spoiled_count+1; cast_onehot stays 0 -> HOLD.
//    4. arm re-asserted -> ignored, no restart.
//  - Latency: vote_pulse edge -> cast_onehot/spoiled = 1 cycle.
//    armed drops in the same cycle the strobe appears.
//  - HOLD: confirm=1 for exactly HOLD_CYCLES cycles, starting the cycle after
//    the strobe is registered, then -> IDLE. vote_pulse, arm and mode are all
//    ignored; a mode change does not shorten HOLD.
//  - cast_onehot is zero or one-hot on every cycle. It is never asserted
//    outside the ARMED->HOLD transition.
//  - Counters saturate at 2**CNT_W-1 and never wrap. The transition and
//    strobes still occur when a counter is saturated.
//  - Hold counter width = $clog2(HOLD_CYCLES+1).
// CONFIGURATION
//  BALLOT_TIMEOUT_EN defined:
//  - An ARMED cycle counter runs from 0 on entry to ARMED.
//  - After TIMEOUT_CYCLES ARMED cycles with no press and mode==0 -> IDLE,
//    with timeout=1 for one cycle.
//  - A press in the expiry cycle wins over the timeout: cast, no timeout pulse.
//  BALLOT_TIMEOUT_EN undefined:
//  - ARMED persists indefinitely.
//  - timeout is tied to 0, and no timeout counter is synthesized.
// TESTING
//  1. Reset low 2 cycles, then arm, then vote_pulse=4'b0010 -> cast_onehot=
//     4'b0010 for 1 cycle; ballots_cast=1; confirm high 10 cycles -> IDLE.
//  2. Armed, vote_pulse=4'b0101 -> spoiled 1 cycle; spoiled_count=1;
//     cast_onehot=0; confirm window 10 cycles.
//  3. vote_pulse=4'b0001 in IDLE and during HOLD -> cast_onehot stays 0;
//     counts unchanged.
//  4. Armed, mode=1 same cycle as vote_pulse=4'b1000 -> IDLE, no cast;
//     arm while mode=1 -> armed stays 0.
//  5. CNT_W=2: 4 valid ballots -> ballots_cast=3 (saturated); cast_onehot still
//     pulses on the 4th.
//  6. BALLOT_TIMEOUT_EN, TIMEOUT_CYCLES=5: arm, idle 5 cycles -> timeout pulse,
//     armed=0. Re-arm; reset low during HOLD -> all outputs 0 next cycle.

Source files
------------

// File: rtl/ballot_session_ctrl_if.sv
// Voter-side bus of the ballot session controller: officer/button inputs,
// logger strobe, status flags and session totals.
interface ballot_session_ctrl_if #(
  parameter int NUM_CAND = 4,
  parameter int CNT_W    = 8
);
  logic                mode;
  logic                arm;
  logic [NUM_CAND-1:0] vote_pulse;
  logic [NUM_CAND-1:0] cast_onehot;
  logic                armed;
  logic                confirm;
  logic                spoiled;
  logic                timeout;
  logic [CNT_W-1:0]    ballots_cast;
  logic [CNT_W-1:0]    spoiled_count;

  modport master (
    output mode, arm, vote_pulse,
    input  cast_onehot, armed, confirm, spoiled, timeout,
    input  ballots_cast, spoiled_count
  );

  modport slave (
    input  mode, arm, vote_pulse,
    output cast_onehot, armed, confirm, spoiled, timeout,
    output ballots_cast, spoiled_count
  );
endinterface

// File: rtl/ballot_session_ctrl.sv
// One-ballot-per-voter sequencer: arm, accept/spoil first press, confirm hold.
// Optional armed-ballot expiry enabled by defining BALLOT_TIMEOUT_EN.
module ballot_session_ctrl #(
  parameter int NUM_CAND       = 4,
  parameter int HOLD_CYCLES    = 10,
  parameter int CNT_W          = 8,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input logic                  clock,
  input logic                  reset,
  ballot_session_ctrl_if.slave bus
);
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    HOLD
  } state_e;

  state_e              state_q;
  logic [HW-1:0]       hold_q;
  logic [NUM_CAND-1:0] cast_q;
  logic                armed_q;
  logic                confirm_q;
  logic                spoiled_q;
  logic [CNT_W-1:0]    cast_cnt_q;
  logic [CNT_W-1:0]    spoil_cnt_q;

  logic any_press;
  logic multi_press;

  assign any_press   = |bus.vote_pulse;
  // clearing the lowest set bit leaves something only if >=2 bits were set
  assign multi_press =
    |(bus.vote_pulse & (bus.vote_pulse - NUM_CAND'(1)));

`ifdef BALLOT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_q;
  logic          timeout_q;
  assign bus.timeout = timeout_q;
`else
  // expiry logic absent; parameter only matters with the feature on
  assign bus.timeout = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      cast_q      <= '0;
      armed_q     <= 1'b0;
      confirm_q   <= 1'b0;
      spoiled_q   <= 1'b0;
      cast_cnt_q  <= '0;
      spoil_cnt_q <= '0;
`ifdef BALLOT_TIMEOUT_EN
      to_q        <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      cast_q    <= '0;
      spoiled_q <= 1'b0;
`ifdef BALLOT_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      unique case (state_q)
        IDLE: begin
          if (bus.arm && !bus.mode) begin
            state_q <= ARMED;
            armed_q <= 1'b1;
`ifdef BALLOT_TIMEOUT_EN
            to_q    <= '0;
`endif
          end
        end
        ARMED: begin
          if (bus.mode) begin
            state_q <= IDLE;
            armed_q <= 1'b0;
          end else if (any_press) begin
            state_q <= HOLD;
            armed_q <= 1'b0;
            hold_q  <= '0;
            if (multi_press) begin
              spoiled_q <= 1'b1;
              if (spoil_cnt_q != {CNT_W{1'b1}})
                spoil_cnt_q <= spoil_cnt_q + CNT_W'(1);
            end else begin
              cast_q <= bus.vote_pulse;
              if (cast_cnt_q != {CNT_W{1'b1}})
                cast_cnt_q <= cast_cnt_q + CNT_W'(1);
            end
          end
`ifdef BALLOT_TIMEOUT_EN
          else if (to_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_q   <= IDLE;
            armed_q   <= 1'b0;
            timeout_q <= 1'b1;
          end else begin
            to_q <= to_q + TW'(1);
          end
`endif
        end
        HOLD: begin
          if (hold_q == HW'(HOLD_CYCLES)) begin
            state_q   <= IDLE;
            confirm_q <= 1'b0;
          end else begin
            confirm_q <= 1'b1;
            hold_q    <= hold_q + HW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cast_onehot   = cast_q;
  assign bus.armed         = armed_q;
  assign bus.confirm       = confirm_q;
  assign bus.spoiled       = spoiled_q;
  assign bus.ballots_cast  = cast_cnt_q;
  assign bus.spoiled_count = spoil_cnt_q;
endmodule

// File: tb/tb_ballot_session_ctrl.sv
// Directed bench for ballot_session_ctrl: main instance plus a CNT_W=2
// instance for counter saturation; expiry checks follow BALLOT_TIMEOUT_EN.
module tb_ballot_session_ctrl;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  ballot_session_ctrl_if #(.NUM_CAND(4), .CNT_W(8)) b1 ();
  ballot_session_ctrl_if #(.NUM_CAND(4), .CNT_W(2)) b2 ();

  ballot_session_ctrl #(
    .NUM_CAND(4), .HOLD_CYCLES(10), .CNT_W(8), .TIMEOUT_CYCLES(5)
  ) dut (
    .clock(clock), .reset(reset), .bus(b1)
  );

  ballot_session_ctrl #(
    .NUM_CAND(4), .HOLD_CYCLES(2), .CNT_W(2), .TIMEOUT_CYCLES(5)
  ) dut_sat (
    .clock(clock), .reset(reset), .bus(b2)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    b1.mode = 1'b0; b1.arm = 1'b0; b1.vote_pulse = '0;
    b2.mode = 1'b0; b2.arm = 1'b0; b2.vote_pulse = '0;
    step();
    step();
    checks++;
    if ({b1.cast_onehot, b1.armed, b1.confirm, b1.spoiled, b1.timeout}
        !== 8'h00) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 00000000",
               {b1.cast_onehot, b1.armed, b1.confirm, b1.spoiled,
                b1.timeout});
    end
    checks++;
    if ({b1.ballots_cast, b1.spoiled_count} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_counts: got %h expected 0000",
               {b1.ballots_cast, b1.spoiled_count});
    end
    checks++;
    if ({b2.cast_onehot, b2.armed, b2.ballots_cast} !== 7'h00) begin
      errors++;
      $display("FAIL reset_sat: got %b expected 0000000",
               {b2.cast_onehot, b2.armed, b2.ballots_cast});
    end
    reset = 1'b1;
    step();
    checks++;
    if (b1.armed !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_armed: got %b expected 0", b1.armed);
    end
  endtask

  task automatic test_cast();
    int n;
    b1.arm = 1'b1;
    step();
    b1.arm = 1'b0;
    checks++;
    if (b1.armed !== 1'b1) begin
      errors++;
      $display("FAIL cast_armed: got %b expected 1", b1.armed);
    end
    b1.vote_pulse = 4'b0010;
    step();
    b1.vote_pulse = '0;
    checks++;
    if (b1.cast_onehot !== 4'b0010) begin
      errors++;
      $display("FAIL cast_strobe: got %b expected 0010", b1.cast_onehot);
    end
    checks++;
    if ({b1.armed, b1.confirm} !== 2'b00) begin
      errors++;
      $display("FAIL cast_armed_drop: got %b expected 00",
               {b1.armed, b1.confirm});
    end
    checks++;
    if (b1.ballots_cast !== 8'd1) begin
      errors++;
      $display("FAIL cast_count: got %0d expected 1", b1.ballots_cast);
    end
    step();
    checks++;
    if ({b1.cast_onehot, b1.confirm} !== 5'b00001) begin
      errors++;
      $display("FAIL cast_one_cycle: got %b expected 00001",
               {b1.cast_onehot, b1.confirm});
    end
    n = 1;
    for (int i = 0; i < 20 && b1.confirm === 1'b1; i++) begin
      step();
      if (b1.confirm === 1'b1) n++;
    end
    checks++;
    if (n !== 10) begin
      errors++;
      $display("FAIL cast_hold_len: got %0d expected 10", n);
    end
  endtask

  task automatic test_spoil();
    int n;
    b1.arm = 1'b1;
    step();
    b1.arm = 1'b0;
    b1.vote_pulse = 4'b0101;
    step();
    b1.vote_pulse = '0;
    checks++;
    if ({b1.spoiled, b1.cast_onehot} !== 5'b10000) begin
      errors++;
      $display("FAIL spoil_strobe: got %b expected 10000",
               {b1.spoiled, b1.cast_onehot});
    end
    checks++;
    if ({b1.spoiled_count, b1.ballots_cast} !== {8'd1, 8'd1}) begin
      errors++;
      $display("FAIL spoil_counts: got %h expected 0101",
               {b1.spoiled_count, b1.ballots_cast});
    end
    step();
    checks++;
    if ({b1.spoiled, b1.confirm} !== 2'b01) begin
      errors++;
      $display("FAIL spoil_one_cycle: got %b expected 01",
               {b1.spoiled, b1.confirm});
    end
    n = 1;
    for (int i = 0; i < 20 && b1.confirm === 1'b1; i++) begin
      step();
      if (b1.confirm === 1'b1) n++;
    end
    checks++;
    if (n !== 10) begin
      errors++;
      $display("FAIL spoil_hold_len: got %0d expected 10", n);
    end
  endtask

  task automatic test_ignored();
    b1.vote_pulse = 4'b0001;
    step();
    b1.vote_pulse = '0;
    checks++;
    if ({b1.cast_onehot, b1.armed, b1.ballots_cast} !== {4'b0, 1'b0, 8'd1})
    begin
      errors++;
      $display("FAIL idle_press: got %b expected 0000000000001",
               {b1.cast_onehot, b1.armed, b1.ballots_cast});
    end
    b1.arm = 1'b1;
    step();
    b1.arm = 1'b0;
    b1.vote_pulse = 4'b0001;
    step();
    checks++;
    if ({b1.cast_onehot, b1.ballots_cast} !== {4'b0001, 8'd2}) begin
      errors++;
      $display("FAIL ign_cast: got %h expected 102",
               {b1.cast_onehot, b1.ballots_cast});
    end
    b1.arm = 1'b1;
    b1.mode = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (b1.cast_onehot !== 4'b0000 || b1.confirm !== 1'b1) begin
        errors++;
        $display("FAIL hold_press_%0d: got %b%b expected 00001",
                 i, b1.cast_onehot, b1.confirm);
      end
    end
    b1.arm = 1'b0;
    b1.mode = 1'b0;
    b1.vote_pulse = '0;
    for (int i = 0; i < 15 && b1.confirm === 1'b1; i++) step();
    checks++;
    if ({b1.armed, b1.confirm, b1.ballots_cast} !== {2'b00, 8'd2}) begin
      errors++;
      $display("FAIL hold_end: got %h expected 002",
               {b1.armed, b1.confirm, b1.ballots_cast});
    end
  endtask

  task automatic test_withdraw();
    b1.arm = 1'b1;
    step();
    b1.arm = 1'b0;
    b1.mode = 1'b1;
    b1.vote_pulse = 4'b1000;
    step();
    b1.vote_pulse = '0;
    checks++;
    if ({b1.armed, b1.cast_onehot, b1.ballots_cast} !== {5'b0, 8'd2}) begin
      errors++;
      $display("FAIL withdraw: got %b expected 0000000000010",
               {b1.armed, b1.cast_onehot, b1.ballots_cast});
    end
    step();
    checks++;
    if ({b1.cast_onehot, b1.confirm} !== 5'b0) begin
      errors++;
      $display("FAIL withdraw_no_hold: got %b expected 00000",
               {b1.cast_onehot, b1.confirm});
    end
    b1.arm = 1'b1;
    step();
    step();
    b1.arm = 1'b0;
    checks++;
    if (b1.armed !== 1'b0) begin
      errors++;
      $display("FAIL arm_in_display: got %b expected 0", b1.armed);
    end
    b1.mode = 1'b0;
    step();
  endtask

  task automatic test_saturate();
    logic [3:0] v;
    logic [1:0] exp_cnt;
    for (int i = 0; i < 4; i++) begin
      v = 4'(1) << i;
      exp_cnt = (i >= 2) ? 2'd3 : 2'(i + 1);
      b2.arm = 1'b1;
      step();
      b2.arm = 1'b0;
      b2.vote_pulse = v;
      step();
      b2.vote_pulse = '0;
      checks++;
      if ({b2.cast_onehot, b2.ballots_cast} !== {v, exp_cnt}) begin
        errors++;
        $display("FAIL sat_ballot_%0d: got %b expected %b",
                 i, {b2.cast_onehot, b2.ballots_cast}, {v, exp_cnt});
      end
      step();
      for (int k = 0; k < 10 && b2.confirm === 1'b1; k++) step();
    end
  endtask

  task automatic test_timeout();
`ifdef BALLOT_TIMEOUT_EN
    b1.arm = 1'b1;
    step();
    b1.arm = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      checks++;
      if ({b1.armed, b1.timeout} !== 2'b10) begin
        errors++;
        $display("FAIL to_wait_%0d: got %b expected 10",
                 i, {b1.armed, b1.timeout});
      end
    end
    step();
    checks++;
    if ({b1.armed, b1.timeout} !== 2'b01) begin
      errors++;
      $display("FAIL to_expire: got %b expected 01",
               {b1.armed, b1.timeout});
    end
    step();
    checks++;
    if (b1.timeout !== 1'b0) begin
      errors++;
      $display("FAIL to_one_cycle: got %b expected 0", b1.timeout);
    end
    b1.arm = 1'b1;
    step();
    b1.arm = 1'b0;
    for (int i = 0; i < 4; i++) step();
`else
    b1.arm = 1'b1;
    step();
    b1.arm = 1'b0;
    for (int i = 0; i < 8; i++) step();
    checks++;
    if ({b1.armed, b1.timeout} !== 2'b10) begin
      errors++;
      $display("FAIL no_expiry: got %b expected 10",
               {b1.armed, b1.timeout});
    end
    b1.mode = 1'b1;
    step();
    b1.mode = 1'b0;
    checks++;
    if (b1.armed !== 1'b0) begin
      errors++;
      $display("FAIL no_expiry_withdraw: got %b expected 0", b1.armed);
    end
    b1.arm = 1'b1;
    step();
    b1.arm = 1'b0;
`endif
    b1.vote_pulse = 4'b0100;
    step();
    b1.vote_pulse = '0;
    checks++;
    if ({b1.cast_onehot, b1.timeout, b1.ballots_cast} !==
        {4'b0100, 1'b0, 8'd3}) begin
      errors++;
      $display("FAIL late_press: got %b expected 0100000000011",
               {b1.cast_onehot, b1.timeout, b1.ballots_cast});
    end
  endtask

  task automatic test_reset_in_hold();
    step();
    checks++;
    if (b1.confirm !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_hold: got %b expected 1", b1.confirm);
    end
    reset = 1'b0;
    step();
    reset = 1'b1;
    checks++;
    if ({b1.cast_onehot, b1.armed, b1.confirm, b1.spoiled, b1.timeout,
         b1.ballots_cast, b1.spoiled_count} !== 24'h0) begin
      errors++;
      $display("FAIL reset_in_hold: got %h expected 000000",
               {b1.cast_onehot, b1.armed, b1.confirm, b1.spoiled,
                b1.timeout, b1.ballots_cast, b1.spoiled_count});
    end
    b1.arm = 1'b1;
    step();
    b1.arm = 1'b0;
    b1.vote_pulse = 4'b1000;
    step();
    b1.vote_pulse = '0;
    checks++;
    if ({b1.cast_onehot, b1.ballots_cast} !== {4'b1000, 8'd1}) begin
      errors++;
      $display("FAIL post_reset_cast: got %h expected 801",
               {b1.cast_onehot, b1.ballots_cast});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_cast();
    test_spoil();
    test_ignored();
    test_withdraw();
    test_saturate();
    test_timeout();
    test_reset_in_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
